// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and a small magnitude helper used by the divider.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 5;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the MD unit.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, SrcA, SrcB, input Busy, HI, LO);
    modport slave  (input Start, MDOp, SrcA, SrcB, output Busy, HI, LO);
endinterface

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign, divide-by-zero is flagged.
module mdu_divider
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        dz_o
);

    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic        q_neg, r_neg, dz;

    // Dividing magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    always_comb begin
        a_mag = abs32(a_i, signed_i);
        b_mag = abs32(b_i, signed_i);
        q_neg = signed_i && (a_i[31] ^ b_i[31]);
        r_neg = signed_i && a_i[31];
        dz    = (b_i == '0);
        q_mag = '0;
        r_mag = '0;
        if (!dz) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo_o = q_neg ? -q_mag : q_mag;
        rem_o = r_neg ? -r_mag : r_mag;
        dz_o  = dz;
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; results are computed at accept
// and committed after a fixed, counter-timed Busy window.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      res_q, res_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo, rem;
    logic        div_dz, div_signed;

    assign div_signed = (md.MDOp == MD_DIV);

    mdu_divider u_div (
        .a_i      (md.SrcA),
        .b_i      (md.SrcB),
        .signed_i (div_signed),
        .quo_o    (quo),
        .rem_o    (rem),
        .dz_o     (div_dz)
    );

    assign prod_s = {{32{md.SrcA[31]}}, md.SrcA} * {{32{md.SrcB[31]}}, md.SrcB};
    assign prod_u = {32'b0, md.SrcA} * {32'b0, md.SrcB};

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        res_d = res_q;
        dz_d  = dz_q;
        cnt_d = cnt_q;
        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && !dz_q) begin
                {hi_d, lo_d} = res_q;
            end
        end else if (md.Start) begin
            case (md.MDOp)
                MD_MULT: begin
                    res_d = prod_s;
                    dz_d  = 1'b0;
                    cnt_d = CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    res_d = prod_u;
                    dz_d  = 1'b0;
                    cnt_d = CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    res_d = {rem, quo};
                    dz_d  = div_dz;
                    cnt_d = CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = md.SrcA;
                MD_MTLO: lo_d = md.SrcA;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            res_q  <= '0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            res_q  <= res_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign md.Busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

    // The hazard unit must stall any MD op while Busy; a violating Start is dropped.
    a_no_start_when_busy: assert property (@(posedge clk) disable iff (reset) !(md.Start && busy_q))
        else $warning("mult_div_unit: Start while Busy ignored");

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a cycle-stamped reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: each accepted op is stamped with its accept cycle;
    // Busy covers the N cycles after it, and HI/LO change at the end of the last one.
    int          cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    bit          m_pend = 0;
    int          m_acc = 0, m_n = 0;
    bit          m_upd = 0;
    logic [63:0] m_res = '0;
    longint          sa, sb;
    longint unsigned ua, ub;

    function automatic bit m_busy(input int c);
        return m_pend && (c > m_acc) && (c <= m_acc + m_n);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_pend = 0;
        end else begin
            if (m_pend && cyc == m_acc + m_n) begin
                if (m_upd) {m_hi, m_lo} = m_res;
                m_pend = 0;
            end else if (bus.Start && !m_busy(cyc)) begin
                sa = $signed(bus.SrcA);
                sb = $signed(bus.SrcB);
                ua = bus.SrcA;
                ub = bus.SrcB;
                case (bus.MDOp)
                    MD_MULT:  begin m_res = sa * sb; m_upd = 1; m_n = NM; m_acc = cyc; m_pend = 1; end
                    MD_MULTU: begin m_res = ua * ub; m_upd = 1; m_n = NM; m_acc = cyc; m_pend = 1; end
                    MD_DIV: begin
                        m_upd = (sb != 0);
                        if (sb != 0) m_res = {32'(sa % sb), 32'(sa / sb)};
                        m_n = ND; m_acc = cyc; m_pend = 1;
                    end
                    MD_DIVU: begin
                        m_upd = (ub != 0);
                        if (ub != 0) m_res = {32'(ua % ub), 32'(ua / ub)};
                        m_n = ND; m_acc = cyc; m_pend = 1;
                    end
                    MD_MTHI: m_hi = bus.SrcA;
                    MD_MTLO: m_lo = bus.SrcA;
                    default: ;
                endcase
            end
            cyc++;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("model_busy", {31'b0, bus.Busy}, {31'b0, m_busy(cyc)});
            chk("model_hi", bus.HI, m_hi);
            chk("model_lo", bus.LO, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        bus.Start = 1'b1; bus.MDOp = op; bus.SrcA = a; bus.SrcB = b;
        @(posedge clk); #2;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_n);
        int n = 0;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            if (bus.Busy) n++;
            else break;
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.Start = 1'b0; bus.MDOp = '0; bus.SrcA = '0; bus.SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        #1 reset = 1'b0;
        cmp_en = 1;

        issue(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        wait_done("mult_busy_len", NM);
        chk("mult_hi", bus.HI, 32'hFFFFFFFF);
        chk("mult_lo", bus.LO, 32'hFFFFFFFA);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_busy_len", NM);
        chk("multu_hi", bus.HI, 32'hFFFFFFFE);
        chk("multu_lo", bus.LO, 32'h00000001);

        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_done("div_busy_len", ND);
        chk("div_hi", bus.HI, 32'hFFFFFFFF);
        chk("div_lo", bus.LO, 32'hFFFFFFFD);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf_busy_len", ND);
        chk("div_ovf_hi", bus.HI, 32'h00000000);
        chk("div_ovf_lo", bus.LO, 32'h80000000);

        issue(MD_MTHI, 32'h00000011, 32'h0);
        @(negedge clk);
        chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mthi_hi", bus.HI, 32'h00000011);
        chk("mthi_lo", bus.LO, 32'h80000000);
        issue(MD_MTLO, 32'h00000022, 32'h0);
        @(negedge clk);
        chk("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mtlo_hi", bus.HI, 32'h00000011);
        chk("mtlo_lo", bus.LO, 32'h00000022);

        issue(MD_DIVU, 32'h12345678, 32'h0);
        wait_done("dz_busy_len", ND);
        chk("dz_hi", bus.HI, 32'h00000011);
        chk("dz_lo", bus.LO, 32'h00000022);

        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk); #2;
        bus.Start = 1'b1; bus.MDOp = MD_MTHI; bus.SrcA = 32'h55; bus.SrcB = '0;
        @(posedge clk); #2;
        bus.Start = 1'b0;
        wait_done("coll_busy_rest", ND - 3);
        chk("coll_hi", bus.HI, 32'd2);
        chk("coll_lo", bus.LO, 32'd14);

        issue(3'd6, 32'hDEADBEEF, 32'hBEEF);
        @(negedge clk);
        chk("rsvd_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rsvd_hi", bus.HI, 32'd2);
        chk("rsvd_lo", bus.LO, 32'd14);

        issue(MD_MULT, 32'd3, 32'd4);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("midrst_hi", bus.HI, 32'd0);
        chk("midrst_lo", bus.LO, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("postrst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("postrst_hi", bus.HI, 32'd0);
        chk("postrst_lo", bus.LO, 32'd0);

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
